// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response and memory-strobe bundle for mem_access_ctrl
interface mem_access_ctrl_if;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy;
  logic        oDone;
  logic        oErr;
  logic [31:0] oRData;
  logic [31:0] oMemEnd;
  logic [31:0] oMemDadoEscrita;
  logic        oMemEscMem;
  logic        oMemLeMem;
  logic [31:0] iMemDado;
  modport slave (
    input  iReq, iWe, iFunct3, iAddr, iWData, iMemDado,
    output oBusy, oDone, oErr, oRData, oMemEnd, oMemDadoEscrita, oMemEscMem, oMemLeMem
  );
  modport master (
    output iReq, iWe, iFunct3, iAddr, iWData, iMemDado,
    input  oBusy, oDone, oErr, oRData, oMemEnd, oMemDadoEscrita, oMemEscMem, oMemLeMem
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: RISC-V load/store initiator for a word-only memory; sub-word ops via MEM_ACCESS_CTRL_SUBWORD_EN
module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 1024
) (
  input logic               iCLK,
  input logic               iRST_n,
  mem_access_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, WT, WR, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_end;
  logic [31:0] r_wd;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_range_err;
  logic        w_f3_err;
  logic        w_align_err;
  logic        w_err;
  assign w_range_err = bus.iAddr >= 32'(ADDR_LIMIT);
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [4:0]  w_sh;
  logic [15:0] w_rsh;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merge;
  assign w_f3_err    = bus.iFunct3 == 3'b011 || bus.iFunct3[2:1] == 2'b11 || (bus.iWe && bus.iFunct3[2]);
  assign w_align_err = (bus.iFunct3[1:0] == 2'b01 && bus.iAddr[0]) ||
                       (bus.iFunct3[1:0] == 2'b10 && bus.iAddr[1:0] != 2'b00);
  assign w_sh    = {r_lane, 3'b000};
  assign w_rsh   = 16'(bus.iMemDado >> w_sh);
  assign w_load  = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_rsh[7]}}, w_rsh[7:0]} :
                   r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_rsh[15]}}, w_rsh} : bus.iMemDado;
  assign w_mask  = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
  assign w_merge = (bus.iMemDado & ~w_mask) | ((r_wd << w_sh) & w_mask);
`else
  assign w_f3_err    = bus.iFunct3 != 3'b010;
  assign w_align_err = bus.iAddr[1:0] != 2'b00;
`endif
  assign w_err = w_range_err | w_f3_err | w_align_err;
  // Access sequencer: latch request, optional read (load or RMW), optional write, one DONE cycle
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= IDLE;
      r_end   <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_lane  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.iReq) begin
          r_end <= {bus.iAddr[31:2], 2'b00};
          r_wd  <= bus.iWData;
          r_err <= w_err;
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
          r_we   <= bus.iWe;
          r_f3   <= bus.iFunct3;
          r_lane <= bus.iAddr[1:0];
`endif
          if (w_err || bus.iWe) r_rdata <= '0;
          r_state <= w_err ? DONE : (bus.iWe && bus.iFunct3 == 3'b010) ? WR : RD;
        end
        RD: r_state <= WT;
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
        WT: begin
          if (r_we) r_wd <= w_merge;
          else r_rdata <= w_load;
          r_state <= r_we ? WR : DONE;
        end
`else
        WT: begin
          r_rdata <= bus.iMemDado;
          r_state <= DONE;
        end
`endif
        WR: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.oBusy           = r_state != IDLE;
  assign bus.oDone           = r_state == DONE;
  assign bus.oMemLeMem       = r_state == RD;
  assign bus.oMemEscMem      = r_state == WR;
  assign bus.oErr            = r_err;
  assign bus.oRData          = r_rdata;
  assign bus.oMemEnd         = r_end;
  assign bus.oMemDadoEscrita = r_wd;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed load/store vectors against a word memory model with registered read data
module tb_mem_access_ctrl;
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem [256];
  int          n_tests = 0;
  int          n_fail = 0;
  mem_access_ctrl_if bus ();
  mem_access_ctrl #(.ADDR_LIMIT(1024)) dut (.iCLK(clk), .iRST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.oMemLeMem) bus.iMemDado <= mem[bus.oMemEnd[9:2]];
    if (bus.oMemEscMem) mem[bus.oMemEnd[9:2]] <= bus.oMemDadoEscrita;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int e_lat, input logic [31:0] e_rd, input bit e_err,
                     input int e_le, input int e_we, input logic [31:0] e_wd, input bit hold = 1'b0);
    int lat, nle, nwe;
    bit done;
    logic [31:0] w_end, w_dat;
    lat = 0; nle = 0; nwe = 0; done = 0; w_end = '0; w_dat = '0;
    @(negedge clk);
    bus.iReq = 1'b1; bus.iWe = we; bus.iFunct3 = f3; bus.iAddr = a; bus.iWData = wd;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.iWe = 1'b1; bus.iFunct3 = 3'b010; bus.iWData = 32'hBAD0_BAD0;
    end else begin
      bus.iReq = 1'b0; bus.iWe = ~we; bus.iAddr = a ^ 32'h4; bus.iWData = ~wd;
    end
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus.oMemLeMem) nle++;
      if (bus.oMemEscMem) begin
        nwe++;
        w_end = bus.oMemEnd;
        w_dat = bus.oMemDadoEscrita;
      end
      if (bus.oDone) done = 1'b1;
    end
    bus.iReq = 1'b0;
    if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, " latency"}, 32'(lat), 32'(e_lat));
      chk({tag, " err"}, 32'(bus.oErr), 32'(e_err));
      if (!we || e_err) chk({tag, " rdata"}, bus.oRData, e_rd);
      chk({tag, " reads"}, 32'(nle), 32'(e_le));
      chk({tag, " writes"}, 32'(nwe), 32'(e_we));
      if (e_we > 0) begin
        chk({tag, " wr_addr"}, w_end, a & ~32'h3);
        chk({tag, " wr_data"}, w_dat, e_wd);
      end
    end
  endtask
  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h15] = 32'd2;
    mem[8'h18] = 32'd5;
    bus.iReq = 1'b0; bus.iWe = 1'b0; bus.iFunct3 = '0; bus.iAddr = '0; bus.iWData = '0; bus.iMemDado = '0;
    #12;
    chk("rst busy", 32'(bus.oBusy), 32'd0);
    chk("rst done", 32'(bus.oDone), 32'd0);
    chk("rst rdata", bus.oRData, 32'd0);
    chk("rst memend", bus.oMemEnd, 32'd0);
    chk("rst strobes", {30'd0, bus.oMemLeMem, bus.oMemEscMem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("lw54", 0, 3'b010, 32'h54, 0, 3, 32'd2, 0, 1, 0, 0);
    run("sw70", 1, 3'b010, 32'h70, 32'hDEADBEEF, 2, 0, 0, 0, 1, 32'hDEADBEEF);
    run("lw70", 0, 3'b010, 32'h70, 0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
    run("sb61", 1, 3'b000, 32'h61, 32'h1234_56AB, SW ? 4 : 1, 0, !SW, SW ? 1 : 0, SW ? 1 : 0, 32'h0000_AB05);
    run("lbu61", 0, 3'b100, 32'h61, 0, SW ? 3 : 1, SW ? 32'h0000_00AB : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("sb62", 1, 3'b000, 32'h62, 32'h0000_0080, SW ? 4 : 1, 0, !SW, SW ? 1 : 0, SW ? 1 : 0, 32'h0080_AB05);
    run("lb62", 0, 3'b000, 32'h62, 0, SW ? 3 : 1, SW ? 32'hFFFF_FF80 : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("lh62", 0, 3'b001, 32'h62, 0, SW ? 3 : 1, SW ? 32'h0000_0080 : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("lhu62", 0, 3'b101, 32'h62, 0, SW ? 3 : 1, SW ? 32'h0000_0080 : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("sh62", 1, 3'b001, 32'h62, 32'h1234_8001, SW ? 4 : 1, 0, !SW, SW ? 1 : 0, SW ? 1 : 0, 32'h8001_AB05);
    run("lh62n", 0, 3'b001, 32'h62, 0, SW ? 3 : 1, SW ? 32'hFFFF_8001 : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("lhu62n", 0, 3'b101, 32'h62, 0, SW ? 3 : 1, SW ? 32'h0000_8001 : 32'h0, !SW, SW ? 1 : 0, 0, 0);
    run("lw60", 0, 3'b010, 32'h60, 0, 3, SW ? 32'h8001_AB05 : 32'd5, 0, 1, 0, 0);
    run("sw3fc", 1, 3'b010, 32'h3FC, 32'h1234_5678, 2, 0, 0, 0, 1, 32'h1234_5678);
    run("lw3fc", 0, 3'b010, 32'h3FC, 0, 3, 32'h1234_5678, 0, 1, 0, 0);
    run("lw52", 0, 3'b010, 32'h52, 0, 1, 0, 1, 0, 0, 0);
    run("lw70b", 0, 3'b010, 32'h70, 0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
    run("sh63", 1, 3'b001, 32'h63, 32'hFFFF, 1, 0, 1, 0, 0, 0);
    run("lw70c", 0, 3'b010, 32'h70, 0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
    run("lw400", 0, 3'b010, 32'h400, 0, 1, 0, 1, 0, 0, 0);
    run("f3_011", 0, 3'b011, 32'h40, 0, 1, 0, 1, 0, 0, 0);
    run("st_f3_100", 1, 3'b100, 32'h40, 32'h1, 1, 0, 1, 0, 0, 0);
    run("lw54hold", 0, 3'b010, 32'h54, 0, 3, 32'd2, 0, 1, 0, 0, 1'b1);
    run("lw54chk", 0, 3'b010, 32'h54, 0, 3, 32'd2, 0, 1, 0, 0);
    @(negedge clk);
    bus.iReq = 1'b1; bus.iWe = 1'b1; bus.iFunct3 = SW ? 3'b000 : 3'b010; bus.iAddr = 32'h68; bus.iWData = 32'h77;
    @(posedge clk);
    #1 bus.iReq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.oMemEscMem;
    end
    chk("rstwr reached WR", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr strobe", 32'(bus.oMemEscMem), 32'd0);
    chk("rstwr busy", 32'(bus.oBusy), 32'd0);
    chk("rstwr done", 32'(bus.oDone), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("lw68", 0, 3'b010, 32'h68, 0, 3, 32'd0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
